phy_tx_lane_mux: RTL and testbench

//   Parametrised N-lane -> 1-lane transmit multiplexer for the PHY TX path, single clock domain.

---
 rtl/phy_tx_lane_mux.sv | 138 +++++++++++++
 tb/tb_phy_tx_lane_mux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lane_mux.sv
// phy_tx_lane_mux: N-lane to 1-lane transmit multiplexer.
// Each lane has a small FIFO. One registered output stage is shared by all lanes and is
// served either by fixed TDM slots or by work-conserving round robin.
module phy_tx_lane_mux #(
    parameter int  LANES      = 4,
    parameter int  DATA_W     = 8,
    parameter int  FIFO_DEPTH = 4,
    parameter int  SKIP_EMPTY = 0,
    localparam int LANE_W     = $clog2(LANES),
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                      clk_f,
    input  logic                      reset,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic [LANES-1:0]          in_ready,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [LANE_W-1:0]         out_lane,
    output logic [LANES*CNT_W-1:0]    fifo_cnt
);

    // Lane index arithmetic modulo LANES; LANES need not be a power of two.
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= LANES) s = s - LANES;
        return LANE_W'(s);
    endfunction

    logic                           r_rdy_en;
    logic                           r_out_valid;
    logic [DATA_W-1:0]              r_out_data;
    logic [LANE_W-1:0]              r_out_lane;
    logic [LANE_W-1:0]              r_ptr;

    logic [LANES-1:0]               w_nonempty;
    logic [LANES-1:0]               w_push;
    logic [LANES-1:0]               w_pop;
    logic [LANES-1:0][DATA_W-1:0]   w_head;
    logic                           w_load;
    logic                           w_found;
    logic [LANE_W-1:0]              w_sel;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PTR_W-1:0]  r_wptr;
            logic [PTR_W-1:0]  r_rptr;
            logic [CNT_W-1:0]  r_cnt;
            logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
            logic              w_full;

            // Readiness comes from the registered count only, so a full lane refuses a word
            // even in a cycle where its head is being popped.
            assign w_full         = (r_cnt == CNT_W'(FIFO_DEPTH));
            assign in_ready[gi]   = r_rdy_en && reset && !w_full;
            assign w_push[gi]     = in_valid[gi] && in_ready[gi];
            assign w_pop[gi]      = w_load && w_found && (w_sel == LANE_W'(gi));
            assign w_nonempty[gi] = (r_cnt != '0);
            assign w_head[gi]     = r_mem[r_rptr];
            assign fifo_cnt[gi*CNT_W +: CNT_W] = r_cnt;

            // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
            always_ff @(posedge clk_f) begin
                if (!reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push[gi]) r_wptr <= r_wptr + PTR_W'(1);
                    if (w_pop[gi])  r_rptr <= r_rptr + PTR_W'(1);
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            // Payload storage; contents are meaningless while the count says empty.
            always_ff @(posedge clk_f) begin
                if (w_push[gi]) r_mem[r_wptr] <= in_data[gi*DATA_W +: DATA_W];
            end
        end
    endgenerate

    // Scheduler: TDM always serves the slot lane; round robin scans from the pointer for work.
    always_comb begin
        w_load  = out_ready || !r_out_valid;
        w_found = 1'b0;
        w_sel   = r_ptr;
        if (SKIP_EMPTY == 0) begin
            w_found = w_nonempty[r_ptr];
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (!w_found && w_nonempty[lane_add(r_ptr, k)]) begin
                    w_found = 1'b1;
                    w_sel   = lane_add(r_ptr, k);
                end
            end
        end
    end

    // Output register and slot pointer; everything holds while downstream stalls a valid word.
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            r_rdy_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_ptr       <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_load) begin
                if (w_found) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_head[w_sel];
                    r_out_lane  <= w_sel;
                    r_ptr       <= lane_add(w_sel, 1);
                end else begin
                    r_out_valid <= 1'b0;
                    if (SKIP_EMPTY == 0) begin
                        r_out_lane <= r_ptr;
                        r_ptr      <= lane_add(r_ptr, 1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_mux.sv
// Bench for phy_tx_lane_mux: a TDM instance and a round-robin instance share one stimulus
// stream; a queue-based reference model predicts each, and emitted words go through a
// scoreboard that the monitor drains on every output handshake.
module tb_phy_tx_lane_mux;
    localparam int L = 4;
    localparam int D = 4;

    logic        clk_f;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  t_in_ready, r_in_ready;
    logic        t_out_valid, r_out_valid;
    logic [7:0]  t_out_data, r_out_data;
    logic [1:0]  t_out_lane, r_out_lane;
    logic [11:0] t_fifo_cnt, r_fifo_cnt;

    phy_tx_lane_mux #(.LANES(4), .DATA_W(8), .FIFO_DEPTH(4), .SKIP_EMPTY(0)) dut_tdm (
        .clk_f(clk_f), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(t_in_ready), .out_ready(out_ready), .out_valid(t_out_valid),
        .out_data(t_out_data), .out_lane(t_out_lane), .fifo_cnt(t_fifo_cnt));

    phy_tx_lane_mux #(.LANES(4), .DATA_W(8), .FIFO_DEPTH(4), .SKIP_EMPTY(1)) dut_rr (
        .clk_f(clk_f), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r_in_ready), .out_ready(out_ready), .out_valid(r_out_valid),
        .out_data(r_out_data), .out_lane(r_out_lane), .fifo_cnt(r_fifo_cnt));

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // Reference model state, index 0 = TDM instance, 1 = round-robin instance.
    logic [7:0] mq [8][$];
    logic [9:0] sb [2][$];
    bit         m_ov [2];
    logic [7:0] m_od [2];
    int         m_ol [2];
    int         m_ptr [2];
    bit         m_en [2];

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, m, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input int skip);
        bit rdy [4];
        bit load;
        bit found;
        int sel;
        if (!reset) begin
            for (int l = 0; l < L; l++) mq[m*4+l].delete();
            sb[m].delete();
            m_ov[m] = 0; m_od[m] = 8'h00; m_ol[m] = 0; m_ptr[m] = 0; m_en[m] = 0;
            return;
        end
        for (int l = 0; l < L; l++) rdy[l] = m_en[m] && (mq[m*4+l].size() < D);
        load = out_ready || !m_ov[m];
        if (load) begin
            found = 0;
            sel = m_ptr[m];
            if (skip == 0) begin
                found = (mq[m*4+sel].size() > 0);
            end else begin
                for (int k = 0; k < L; k++) begin
                    int c;
                    c = (m_ptr[m] + k) % L;
                    if (!found && mq[m*4+c].size() > 0) begin
                        found = 1;
                        sel = c;
                    end
                end
            end
            if (found) begin
                m_od[m] = mq[m*4+sel].pop_front();
                m_ol[m] = sel;
                m_ov[m] = 1;
                sb[m].push_back({sel[1:0], m_od[m]});
                m_ptr[m] = (sel + 1) % L;
            end else begin
                m_ov[m] = 0;
                if (skip == 0) begin
                    m_ol[m] = m_ptr[m];
                    m_ptr[m] = (m_ptr[m] + 1) % L;
                end
            end
        end
        for (int l = 0; l < L; l++)
            if (in_valid[l] && rdy[l]) mq[m*4+l].push_back(in_data[l*8 +: 8]);
        m_en[m] = 1;
    endtask

    // Advance both reference models on every active edge.
    always @(posedge clk_f) begin
        model_step(0, 0);
        model_step(1, 1);
    end

    task automatic check_dut(input int m, input logic v, input logic [7:0] d, input logic [1:0] ln,
                             input logic [3:0] rdy, input logic [11:0] cnt);
        logic [3:0] e_rdy;
        logic [9:0] e_word;
        for (int l = 0; l < L; l++) begin
            e_rdy[l] = m_en[m] && reset && (mq[m*4+l].size() < D);
            chk("fifo_cnt", m, 32'(cnt[l*3 +: 3]), 32'(mq[m*4+l].size()));
        end
        chk("in_ready", m, 32'(rdy), 32'(e_rdy));
        chk("out_valid", m, 32'(v), 32'(m_ov[m]));
        chk("out_data", m, 32'(d), 32'(m_od[m]));
        chk("out_lane", m, 32'(ln), 32'(m_ol[m]));
        if (v && out_ready) begin
            if (sb[m].size() == 0) begin
                chk("unexpected_word", m, 32'({ln, d}), 32'hFFFF_FFFF);
            end else begin
                e_word = sb[m].pop_front();
                chk("sb_word", m, 32'({ln, d}), 32'(e_word));
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk_f) begin
        if (chk_on) begin
            check_dut(0, t_out_valid, t_out_data, t_out_lane, t_in_ready, t_fifo_cnt);
            check_dut(1, r_out_valid, r_out_data, r_out_lane, r_in_ready, r_fifo_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_f);
    endtask

    task automatic put(input int lane, input logic [7:0] d);
        in_valid[lane] = 1'b1;
        in_data[lane*8 +: 8] = d;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 4'hF;
        in_data = 32'h1234_5678;
        out_ready = 1'b1;
        @(posedge clk_f);
        @(negedge clk_f);
        chk_on = 1;
        cyc(2);
        chk("rst_in_ready", 0, 32'(t_in_ready), 32'h0);
        chk("rst_out_data", 1, 32'(r_out_data), 32'h0);
        chk("rst_fifo_cnt", 0, 32'(t_fifo_cnt), 32'h0);
        reset = 1'b1;
        in_valid = 4'h0;
        cyc(1);
        chk("rel_in_ready", 0, 32'(t_in_ready), 32'hF);
        chk("rel_in_ready", 1, 32'(r_in_ready), 32'hF);

        // One word per lane in the same cycle.
        for (int l = 0; l < L; l++) put(l, 8'(8'hA0 + l));
        cyc(1);
        in_valid = 4'h0;
        cyc(10);

        // Only lane 2 loaded.
        put(2, 8'h55);
        cyc(1);
        in_valid = 4'h0;
        cyc(8);

        // Lane 1 gets three words, lane 3 one.
        put(1, 8'h11); put(3, 8'h31);
        cyc(1);
        in_valid = 4'h0;
        put(1, 8'h12);
        cyc(1);
        put(1, 8'h13);
        cyc(1);
        in_valid = 4'h0;
        cyc(10);

        // Back-pressure on lane 0 with an extra word offered to a full FIFO.
        out_ready = 1'b0;
        for (int w = 0; w < 6; w++) begin
            put(0, 8'(8'hC0 + w));
            cyc(1);
        end
        in_valid = 4'h0;
        cyc(5);
        out_ready = 1'b1;
        cyc(12);

        // Reset with two words queued per lane.
        out_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int l = 0; l < L; l++) put(l, 8'(8'hE0 + 4*w + l));
            cyc(1);
        end
        in_valid = 4'h0;
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(10);

        // Randomized traffic with stalls and rare resets.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 299) != 0);
            cyc(1);
        end

        // Drain and confirm nothing was lost.
        reset = 1'b1;
        in_valid = 4'h0;
        out_ready = 1'b1;
        cyc(40);
        chk("drain_sb", 0, 32'(sb[0].size()), 32'h0);
        chk("drain_sb", 1, 32'(sb[1].size()), 32'h0);
        chk("drain_cnt", 0, 32'(t_fifo_cnt), 32'h0);
        chk("drain_cnt", 1, 32'(r_fifo_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
